// File: rtl/done_collector.sv
// Completion collector: sticky per-channel done flags against a per-instruction mask,
// one held allDone until ack. Optional COLLECT timeout via DONE_COLLECT_TIMEOUT_EN.
module done_collector #(
  parameter int unsigned NUM_CH      = 4,
  parameter int unsigned TIMEOUT_CYC = 200
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [NUM_CH-1:0] chanMask,
  input  logic [NUM_CH-1:0] chanDone,
  input  logic              ack,
  output logic              allDone,
  output logic              busy,
  output logic [NUM_CH-1:0] pendingMask,
  output logic              timeoutErr,
  output logic [7:0]        instrCount
);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDone    = 2'd2;

  logic [1:0]        stateQ, stateD;
  logic [NUM_CH-1:0] pendQ, pendD;
  logic [7:0]        cntQ, cntD;
  logic              allDoneQ, busyQ;

  logic [NUM_CH-1:0] loadMask;
  logic [NUM_CH-1:0] collectMask;
  logic              timeoutHit;

  // A done seen in the same cycle as start already counts.
  assign loadMask    = chanMask & ~chanDone;
  assign collectMask = pendQ & ~chanDone;

  always_comb begin
    stateD = stateQ;
    pendD  = pendQ;
    cntD   = cntQ;
    case (stateQ)
      StIdle: begin
        if (start) begin
          pendD  = loadMask;
          stateD = (loadMask == '0) ? StDone : StCollect;
        end
      end
      StCollect: begin
        pendD = collectMask;
        if (collectMask == '0) begin
          stateD = StDone;
        end else if (timeoutHit) begin
          // pendingMask stays frozen on the channels that never reported.
          stateD = StDone;
        end
      end
      StDone: begin
        if (ack) begin
          cntD = cntQ + 8'd1;
          if (start) begin
            pendD  = loadMask;
            stateD = (loadMask == '0) ? StDone : StCollect;
          end else begin
            pendD  = '0;
            stateD = StIdle;
          end
        end
      end
      default: begin
        pendD  = '0;
        stateD = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateQ   <= StIdle;
      pendQ    <= '0;
      cntQ     <= '0;
      allDoneQ <= 1'b0;
      busyQ    <= 1'b0;
    end else begin
      stateQ   <= stateD;
      pendQ    <= pendD;
      cntQ     <= cntD;
      allDoneQ <= (stateD == StDone);
      busyQ    <= (stateD == StCollect);
    end
  end

`ifdef DONE_COLLECT_TIMEOUT_EN
  localparam int unsigned TmrW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [TmrW-1:0] tmrQ;
  logic            errQ;

  assign timeoutHit = (tmrQ == TmrW'(TIMEOUT_CYC - 1));

  // Counter sits at zero outside COLLECT, so it starts fresh on every entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      tmrQ <= '0;
      errQ <= 1'b0;
    end else begin
      if (stateQ == StCollect) begin
        tmrQ <= tmrQ + TmrW'(1);
      end else begin
        tmrQ <= '0;
      end
      if (stateQ == StCollect && collectMask != '0 && timeoutHit) begin
        errQ <= 1'b1;
      end else if (stateQ == StDone && ack) begin
        errQ <= 1'b0;
      end
    end
  end

  assign timeoutErr = errQ;
`else
  assign timeoutHit = 1'b0;
  assign timeoutErr = 1'b0;
`endif

  assign allDone     = allDoneQ;
  assign busy        = busyQ;
  assign pendingMask = pendQ;
  assign instrCount  = cntQ;

endmodule

// File: tb/tb_done_collector.sv
// Bench for done_collector: directed scenarios plus randomized traffic against a
// cycle-level reference model of the collection rules.
module tb_done_collector;

  localparam int N  = 4;
  localparam int TO = 10;
`ifdef DONE_COLLECT_TIMEOUT_EN
  localparam bit ToEn = 1'b1;
`else
  localparam bit ToEn = 1'b0;
`endif

  logic         clk;
  logic         reset;
  logic         start;
  logic [N-1:0] chanMask;
  logic [N-1:0] chanDone;
  logic         ack;
  logic         allDone;
  logic         busy;
  logic [N-1:0] pendingMask;
  logic         timeoutErr;
  logic [7:0]   instrCount;

  done_collector #(
    .NUM_CH     (N),
    .TIMEOUT_CYC(TO)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .chanMask   (chanMask),
    .chanDone   (chanDone),
    .ack        (ack),
    .allDone    (allDone),
    .busy       (busy),
    .pendingMask(pendingMask),
    .timeoutErr (timeoutErr),
    .instrCount (instrCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: 0 = waiting, 1 = collecting, 2 = complete.
  int         mPhase = 0;
  logic [3:0] mPend  = '0;
  logic [7:0] mCnt   = '0;
  logic       mErr   = 1'b0;
  int         mCc    = 0;

  function automatic logic [14:0] obs();
    return {allDone, busy, timeoutErr, pendingMask, instrCount};
  endfunction

  function automatic logic [14:0] mExp();
    return {mPhase == 2, mPhase == 1, mErr, mPend, mCnt};
  endfunction

  function automatic logic [14:0] ex(input logic d, input logic b, input logic e,
                                     input logic [3:0] p, input logic [7:0] c);
    return {d, b, e, p, c};
  endfunction

  task automatic mLoad(input logic [3:0] m, input logic [3:0] d);
    mPend  = m & ~d;
    mCc    = 0;
    mPhase = (mPend == 0) ? 2 : 1;
  endtask

  // Apply one cycle of inputs, advance the model, then sit 1 time unit past the edge.
  task automatic drive(input logic r, input logic s, input logic [3:0] m,
                       input logic [3:0] d, input logic a);
    reset = r; start = s; chanMask = m; chanDone = d; ack = a;
    @(posedge clk);
    if (r) begin
      mPhase = 0; mPend = '0; mCnt = '0; mErr = 1'b0; mCc = 0;
    end else if (mPhase == 0) begin
      if (s) mLoad(m, d);
    end else if (mPhase == 1) begin
      mPend = mPend & ~d;
      mCc++;
      if (mPend == 0) mPhase = 2;
      else if (ToEn && mCc == TO) begin
        mPhase = 2;
        mErr   = 1'b1;
      end
    end else if (a) begin
      mCnt++;
      mErr = 1'b0;
      if (s) mLoad(m, d);
      else begin
        mPhase = 0;
        mPend  = '0;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    drive(1, 0, 4'b0, 4'b0, 0);
    drive(1, 0, 4'b0, 4'b0, 0);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd0))
      $display("FAIL reset_initial got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd0));
    drive(0, 1, 4'b1111, 4'b0, 0);
    checks++;
    if (obs() !== ex(0, 1, 0, 4'b1111, 8'd0)) begin
      errors++;
      $display("FAIL reset_enter_collect got=%b exp=%b", obs(), ex(0, 1, 0, 4'b1111, 8'd0));
    end
    drive(1, 0, 4'b0, 4'b0, 0);
    drive(1, 0, 4'b0, 4'b0, 0);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd0)) begin
      errors++;
      $display("FAIL reset_mid_collect got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd0));
    end
    drive(0, 0, 4'b0, 4'b1111, 0);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd0)) begin
      errors++;
      $display("FAIL reset_stays_idle got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd0));
    end
  endtask

  task automatic test_basic();
    logic [3:0] pulses [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    logic [3:0] steps  [4] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000};
    drive(0, 1, 4'b1111, 4'b0, 0);
    checks++;
    if (obs() !== ex(0, 1, 0, 4'b1111, 8'd0)) begin
      errors++;
      $display("FAIL basic_start got=%b exp=%b", obs(), ex(0, 1, 0, 4'b1111, 8'd0));
    end
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 4'b0, pulses[i], 0);
      checks++;
      if (obs() !== ex(i == 3, i != 3, 0, steps[i], 8'd0)) begin
        errors++;
        $display("FAIL basic_step%0d got=%b exp=%b", i, obs(), ex(i == 3, i != 3, 0, steps[i], 8'd0));
      end
    end
    drive(0, 1, 4'b1111, 4'b0, 0);  // start without ack is ignored in DONE
    checks++;
    if (obs() !== ex(1, 0, 0, 4'b0000, 8'd0)) begin
      errors++;
      $display("FAIL basic_hold got=%b exp=%b", obs(), ex(1, 0, 0, 4'b0000, 8'd0));
    end
    drive(0, 0, 4'b0, 4'b0, 1);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd1)) begin
      errors++;
      $display("FAIL basic_ack got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd1));
    end
  endtask

  task automatic test_partial();
    drive(0, 1, 4'b0101, 4'b0001, 0);
    checks++;
    if (obs() !== ex(0, 1, 0, 4'b0100, 8'd1)) begin
      errors++;
      $display("FAIL partial_start got=%b exp=%b", obs(), ex(0, 1, 0, 4'b0100, 8'd1));
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, i == 1, 4'b1111, 4'b1010, i == 2);  // out-of-mask done, stray start/ack
      checks++;
      if (obs() !== ex(0, 1, 0, 4'b0100, 8'd1)) begin
        errors++;
        $display("FAIL partial_wait%0d got=%b exp=%b", i, obs(), ex(0, 1, 0, 4'b0100, 8'd1));
      end
    end
    drive(0, 0, 4'b0, 4'b0100, 0);
    checks++;
    if (obs() !== ex(1, 0, 0, 4'b0000, 8'd1)) begin
      errors++;
      $display("FAIL partial_done got=%b exp=%b", obs(), ex(1, 0, 0, 4'b0000, 8'd1));
    end
    drive(0, 0, 4'b0, 4'b0, 1);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd2)) begin
      errors++;
      $display("FAIL partial_ack got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd2));
    end
  endtask

  task automatic test_back_to_back();
    drive(0, 1, 4'b0000, 4'b0, 0);
    checks++;
    if (obs() !== ex(1, 0, 0, 4'b0000, 8'd2)) begin
      errors++;
      $display("FAIL b2b_empty_mask got=%b exp=%b", obs(), ex(1, 0, 0, 4'b0000, 8'd2));
    end
    drive(0, 1, 4'b0011, 4'b0, 1);
    checks++;
    if (obs() !== ex(0, 1, 0, 4'b0011, 8'd3)) begin
      errors++;
      $display("FAIL b2b_restart got=%b exp=%b", obs(), ex(0, 1, 0, 4'b0011, 8'd3));
    end
    drive(0, 0, 4'b0, 4'b0011, 0);
    checks++;
    if (obs() !== ex(1, 0, 0, 4'b0000, 8'd3)) begin
      errors++;
      $display("FAIL b2b_complete got=%b exp=%b", obs(), ex(1, 0, 0, 4'b0000, 8'd3));
    end
    drive(0, 1, 4'b0001, 4'b0001, 1);  // new mask already satisfied: allDone stays up
    checks++;
    if (obs() !== ex(1, 0, 0, 4'b0000, 8'd4)) begin
      errors++;
      $display("FAIL b2b_presatisfied got=%b exp=%b", obs(), ex(1, 0, 0, 4'b0000, 8'd4));
    end
    drive(0, 0, 4'b0, 4'b0, 1);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd5)) begin
      errors++;
      $display("FAIL b2b_final_ack got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd5));
    end
  endtask

  task automatic test_timeout();
    drive(0, 1, 4'b0011, 4'b0001, 0);
    checks++;
    if (obs() !== ex(0, 1, 0, 4'b0010, 8'd5)) begin
      errors++;
      $display("FAIL timeout_start got=%b exp=%b", obs(), ex(0, 1, 0, 4'b0010, 8'd5));
    end
    for (int i = 0; i < TO - 1; i++) begin
      drive(0, 0, 4'b0, 4'b0, 0);
      checks++;
      if (obs() !== ex(0, 1, 0, 4'b0010, 8'd5)) begin
        errors++;
        $display("FAIL timeout_wait%0d got=%b exp=%b", i, obs(), ex(0, 1, 0, 4'b0010, 8'd5));
      end
    end
    if (ToEn) begin
      drive(0, 0, 4'b0, 4'b0, 0);
      checks++;
      if (obs() !== ex(1, 0, 1, 4'b0010, 8'd5)) begin
        errors++;
        $display("FAIL timeout_fire got=%b exp=%b", obs(), ex(1, 0, 1, 4'b0010, 8'd5));
      end
      drive(0, 0, 4'b0, 4'b0010, 0);  // late done in DONE has no effect
      checks++;
      if (obs() !== ex(1, 0, 1, 4'b0010, 8'd5)) begin
        errors++;
        $display("FAIL timeout_hold got=%b exp=%b", obs(), ex(1, 0, 1, 4'b0010, 8'd5));
      end
    end else begin
      for (int i = 0; i < 4 * TO; i++) begin
        drive(0, 0, 4'b0, 4'b0, 0);
        checks++;
        if (obs() !== ex(0, 1, 0, 4'b0010, 8'd5)) begin
          errors++;
          $display("FAIL notimeout_wait%0d got=%b exp=%b", i, obs(), ex(0, 1, 0, 4'b0010, 8'd5));
        end
      end
      drive(0, 0, 4'b0, 4'b0010, 0);
      checks++;
      if (obs() !== ex(1, 0, 0, 4'b0000, 8'd5)) begin
        errors++;
        $display("FAIL notimeout_done got=%b exp=%b", obs(), ex(1, 0, 0, 4'b0000, 8'd5));
      end
    end
    drive(0, 0, 4'b0, 4'b0, 1);
    checks++;
    if (obs() !== ex(0, 0, 0, 4'b0000, 8'd6)) begin
      errors++;
      $display("FAIL timeout_ack got=%b exp=%b", obs(), ex(0, 0, 0, 4'b0000, 8'd6));
    end
  endtask

  task automatic test_wrap();
    logic [7:0] want;
    drive(1, 0, 4'b0, 4'b0, 0);
    for (int i = 0; i < 256; i++) begin
      drive(0, 1, 4'b0000, 4'b0, 0);
      drive(0, 0, 4'b0, 4'b0, 1);
      want = 8'((i + 1) % 256);
      checks++;
      if (instrCount !== want || allDone !== 1'b0) begin
        errors++;
        $display("FAIL wrap_count%0d got=%0d/%b exp=%0d/0", i, instrCount, allDone, want);
      end
    end
    checks++;
    if (instrCount !== 8'd0) begin
      errors++;
      $display("FAIL wrap_zero got=%0d exp=0", instrCount);
    end
  endtask

  task automatic test_random();
    logic       r, s, a;
    logic [3:0] m, d;
    drive(1, 0, 4'b0, 4'b0, 0);
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 99) == 0);
      s = $urandom_range(0, 1);
      a = ($urandom_range(0, 2) != 0);
      m = 4'($urandom);
      d = 4'($urandom) & 4'($urandom);
      drive(r, s, m, d, a);
      checks++;
      if (obs() !== mExp()) begin
        errors++;
        $display("FAIL random_cycle%0d got=%b exp=%b", i, obs(), mExp());
      end
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; chanMask = '0; chanDone = '0; ack = 1'b0;
    test_reset();
    test_basic();
    test_partial();
    test_back_to_back();
    test_timeout();
    test_wrap();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/done_collector.md
# done_collector

Parametrised completion collector for the K1 processor. It tracks up to NUM_CH per-instruction completion sources, such as branch, jump and the memory write ports. Each source has a sticky flag, and the per-instruction required-channel mask is loaded at instruction start. The block asserts one held completion signal when every required channel has reported, and holds it until the control unit acknowledges. It sits between the execute/memory units and the control FSM, and it is the next generation of the fixed four-input done combiner.

## Interface
Parameters:
- NUM_CH, 4: number of completion channels (1..16).
- TIMEOUT_CYC, 200: COLLECT-state cycle limit before a timeout. Used only when DONE_COLLECT_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock. All state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  begin collection for a new instruction. Accepted in IDLE, or in DONE together with ack.
- chanMask  in  NUM_CH  channels required for this instruction. Sampled only on an accepted start.
- chanDone  in  NUM_CH  per-channel done indication. A pulse or a level; either is treated as sticky once seen.
- ack  in  1  control unit consumes the completion. Meaningful only while allDone=1.
- allDone  out  1  all required channels have reported (or timeout). Held until ack.
- busy  out  1  high in COLLECT.
- pendingMask  out  NUM_CH  required channels not yet reported.
- timeoutErr  out  1  sticky timeout flag for the current instruction.
- instrCount  out  8  count of acknowledged completions, wraps 255 -> 0.

## Operation
- State machine: IDLE, COLLECT, DONE. All outputs are registered.
- Reset: state=IDLE, allDone=0, busy=0, pendingMask=0, timeoutErr=0, instrCount=0, timeout counter=0.
- IDLE, start=1:
  - pendingMask <= chanMask & ~chanDone. A done seen in the start cycle counts.
  - If that result is zero, go to DONE. This includes chanMask=0.
  - Otherwise go to COLLECT.
- IDLE, start=0: stay in IDLE.
- COLLECT:
  - Each cycle, pendingMask <= pendingMask & ~chanDone.
  - When the updated value is zero, go to DONE.
  - chanDone bits outside the mask are ignored.
  - start and ack are ignored. Protocol error, no state change.
- DONE:
  - allDone=1 and pendingMask are held.
  - ack=1: instrCount += 1 and timeoutErr is cleared.
  - ack=1 with start=0: go to IDLE.
  - ack=1 with start=1 (back-to-back): load the new mask exactly as the IDLE start rule, with no idle bubble.
  - ack=0: start is ignored.
- chanDone arriving in IDLE or DONE has no effect. Flags are sticky only within COLLECT or the start cycle.
- Reset mid-COLLECT or mid-DONE: the instruction is abandoned, all outputs return to reset values, and instrCount is not incremented.

## Timing
- The last required chanDone seen in cycle t gives allDone=1 from cycle t+1.
- start in cycle t with all mask bits already done, or mask=0, gives allDone=1 at t+1.
- ack in cycle t gives allDone=0 at t+1, with instrCount updated at t+1.
- With back-to-back ack+start at t, busy=1 at t+1 (or allDone stays 1 if the new mask is already satisfied).
- Minimum instruction turnaround is 2 cycles: start, then ack.
- busy is high exactly in the cycles spent in COLLECT.

## Configuration
- DONE_COLLECT_TIMEOUT_EN defined:
  - A counter clears on entry to COLLECT and increments each COLLECT cycle.
  - When it reaches TIMEOUT_CYC without completing, the block goes to DONE with allDone=1 and timeoutErr=1.
  - pendingMask is frozen to show the missing channels.
  - timeoutErr clears on ack or reset.
- DONE_COLLECT_TIMEOUT_EN not defined:
  - No counter is built and timeoutErr is tied 0.
  - COLLECT waits indefinitely.

## Test plan
- Reset: assert reset for 2 cycles mid-COLLECT -> allDone=0, busy=0, pendingMask=0, instrCount=0, state IDLE.
- Basic collection, NUM_CH=4:
  - Stimulus: start with chanMask=4'b1111, then chanDone pulses 0001, 0010, 0100, 1000 on successive cycles.
  - Response: pendingMask steps 1110, 1100, 1000, 0000, and allDone=1 the cycle after the last pulse.
  - ack -> allDone=0, instrCount=1.
- Partial mask and same-cycle done:
  - Stimulus: start with chanMask=4'b0101 and chanDone=4'b0001 in the start cycle, then chanDone=4'b1010 for 3 cycles.
  - Response: pendingMask=0100, busy stays 1, no completion.
  - Then chanDone=0100 -> allDone=1 next cycle.
- Empty mask and back-to-back:
  - Stimulus: start with chanMask=0 -> allDone=1 next cycle.
  - Then ack+start with chanMask=0011 in the same cycle -> busy=1 next cycle, instrCount=1.
- Timeout, macro defined, TIMEOUT_CYC=10:
  - Stimulus: start with chanMask=0011, only bit 0 done.
  - Response: after 10 COLLECT cycles, allDone=1, timeoutErr=1, pendingMask=0010.
  - ack -> timeoutErr=0.
  - Without the macro, the same stimulus leaves busy=1 indefinitely.
- Counter wrap: 256 ack'd completions -> instrCount returns to 0.
